prio_encoder_rr: RTL and testbench
==================================

// Module: prio_encoder_rr
// PURPOSE
//  Parametrised, registered successor to the 4-to-2 encoder. Accepts an N-bit request
//  vector and serialises every set bit into a binary index stream, one index per output
//  handshake. Supports fixed priority and round-robin mode. Sits between a request
//  source (IRQ/status collector) and a single-index consumer (dispatcher, mux select).
// PARAMETERS
//  N          8   request vector width, N >= 2; non-power-of-two allowed
//  W          $clog2(N)   index width (derived localparam, not overridable)
//  MSB_FIRST  0   fixed mode only: 0 = lowest set bit first, 1 = highest set bit first
// PORTS
//  clk        in   1    single clock, all logic on rising edge
//  rst        in   1    synchronous, active-high reset
//  mode       in   1    0 = fixed priority, 1 = round-robin; sampled on vector accept
//  req_i      in   N    request vector
//  req_valid  in   1    req_i valid
//  req_ready  out  1    block can accept a vector
//  idx_o      out  W    binary index of current set bit
//  onehot_o   out  N    one-hot of idx_o (all zero when zero_o=1)
//  zero_o     out  1    accepted vector was all zero
//  last_o     out  1    current beat is the final beat of this vector
//  out_valid  out  1    idx_o/onehot_o/zero_o/last_o valid
//  out_ready  in   1    consumer accepts current beat
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, pending=0, ptr=0, mode_q=0; outputs req_ready=1
//    (after reset), out_valid=0, idx_o=0, onehot_o=0, zero_o=0, last_o=0. Reset mid-scan
//    discards pending bits; no further beats for that vector.
//  - FSM IDLE: req_ready=1, out_valid=0. req_valid&req_ready at edge T -> pending<=req_i,
//    mode_q<=mode, state<=SCAN. First out_valid at T+1 (latency 1 cycle).
//  - FSM SCAN: req_ready=0, out_valid=1. Outputs are registered, stable while out_valid&
//    !out_ready (no change in idx/onehot/zero/last under stall).
//  - Beat select: fixed mode -> lowest (MSB_FIRST=0) or highest (MSB_FIRST=1) set bit of
//    pending. RR mode -> first set bit at or above ptr, wrapping N-1 -> 0; idx never >= N.
//  - Handshake out_valid&out_ready: clear pending[idx]; RR mode ptr <= (idx==N-1)?0:idx+1
//    (ptr persists across vectors; fixed mode leaves ptr untouched). If last_o=1 ->
//    state<=IDLE; req_ready=1 next cycle (one bubble cycle between vectors, by design).
//  - last_o=1 iff popcount(pending)==1, or zero_o=1.
//  - Zero vector: exactly one beat with zero_o=1, idx_o=0, onehot_o=0, last_o=1; ptr unchanged.
//  - req_valid while req_ready=0 is ignored (source must hold). mode changes during SCAN
//    have no effect until next accept.
// STRUCTURE
//  - Shared package prio_enc_pkg: state encoding localparams (ST_IDLE, ST_SCAN), clog2
//    function, mode encoding constants (MODE_FIXED, MODE_RR).
//  - One sub-module prio_scan (combinational): inputs vec[N], start[W], dir; outputs
//    found, idx[W]; implements rotate-by-start + find-first + wrap. Top holds FSM,
//    pending/ptr registers, output registers and next-beat precompute.
// TESTING
//  1. N=8 fixed, MSB_FIRST=0: req 8'b1010_0110, out_ready=1 -> idx 1,2,5,7; last_o on 7; then req_ready=1.
//  2. N=8 RR: vec 8'b1000_0001 -> 0,7 (ptr=0); next vec 8'b1000_0001 -> 0,7 again; vec 8'b0001_0001 after ptr=3 -> 4,0.
//  3. Stall: req 8'b0000_1100, hold out_ready=0 five cycles -> idx_o=2 stable, out_valid=1; release -> 2 then 3.
//  4. Zero vector 8'h00 -> single beat zero_o=1, last_o=1, onehot_o=0; ptr unchanged.
//  5. Reset mid-scan: req 8'hFF, rst after 2 beats -> out_valid=0 next cycle, req_ready=1, ptr=0, no stale beats.
//  6. N=5, MSB_FIRST=1 fixed: req 5'b10011 -> idx 4,1,0; RR req 5'b10000 ptr wraps to 0 after idx 4.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the round-robin / fixed-priority index serialiser.
// These are the FSM state encoding, the mode encoding and a width helper.
package prio_enc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/prio_scan.sv
// Circular find-first: searches vec from start, upward (dir=0) or downward (dir=1).
// The search wraps around the ends of the vector and never reports an index >= N.
module prio_scan #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  input  logic         dir,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int p;
    p     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (dir) p = int'(start) - k;
      else     p = int'(start) + k;
      if (p >= N)     p = p - N;
      else if (p < 0) p = p + N;
      if (!found && vec[p[W-1:0]]) begin
        found = 1'b1;
        idx   = p[W-1:0];
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered request-vector serialiser: emits one binary index per handshake for every
// set bit of an accepted vector, in fixed-priority or round-robin order.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int  N         = 8,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int W         = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic [N-1:0] req_i,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o,
  output logic         zero_o,
  output logic         last_o,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t       state, state_nxt;
  logic [N-1:0] pending, pending_nxt;
  logic [W-1:0] ptr, ptr_nxt;
  logic         mode_q, mode_nxt;
  logic [W-1:0] idx_nxt;
  logic [N-1:0] onehot_nxt;
  logic         zero_nxt, last_nxt;

  logic [N-1:0] pend_clr, scan_vec, beat_onehot;
  logic [W-1:0] ptr_adv, ptr_hs, ptr_base, scan_start, scan_idx;
  logic         scan_mode, scan_dir, scan_found, beat_last;

  assign req_ready = (state == ST_IDLE);
  assign out_valid = (state == ST_SCAN);

  // Next beat is precomputed from the vector being accepted (IDLE) or from what remains
  // after the current beat retires (SCAN), so outputs can be registered with no bubble.
  assign pend_clr  = pending & ~onehot_o;
  assign ptr_adv   = (idx_o == W'(N - 1)) ? '0 : idx_o + W'(1);
  assign ptr_hs    = (mode_q == MODE_RR && !zero_o) ? ptr_adv : ptr;

  assign scan_vec   = (state == ST_IDLE) ? req_i : pend_clr;
  assign scan_mode  = (state == ST_IDLE) ? mode  : mode_q;
  assign ptr_base   = (state == ST_IDLE) ? ptr   : ptr_hs;
  assign scan_start = (scan_mode == MODE_RR) ? ptr_base : (MSB_FIRST ? W'(N - 1) : '0);
  assign scan_dir   = (scan_mode == MODE_FIXED) && MSB_FIRST;

  prio_scan #(.N(N), .W(W)) u_scan (
    .vec   (scan_vec),
    .start (scan_start),
    .dir   (scan_dir),
    .found (scan_found),
    .idx   (scan_idx)
  );

  // A zero vector also yields last, giving it exactly one beat.
  assign beat_last = ((scan_vec & (scan_vec - N'(1))) == '0);

  always_comb begin
    beat_onehot           = '0;
    beat_onehot[scan_idx] = scan_found;
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    ptr_nxt     = ptr;
    mode_nxt    = mode_q;
    idx_nxt     = idx_o;
    onehot_nxt  = onehot_o;
    zero_nxt    = zero_o;
    last_nxt    = last_o;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt   = ST_SCAN;
          pending_nxt = req_i;
          mode_nxt    = mode;
          idx_nxt     = scan_idx;
          onehot_nxt  = beat_onehot;
          zero_nxt    = !scan_found;
          last_nxt    = beat_last;
        end
      end
      ST_SCAN: begin
        if (out_ready) begin
          ptr_nxt = ptr_hs;
          if (last_o) begin
            state_nxt   = ST_IDLE;
            pending_nxt = '0;
            idx_nxt     = '0;
            onehot_nxt  = '0;
            zero_nxt    = 1'b0;
            last_nxt    = 1'b0;
          end else begin
            pending_nxt = pend_clr;
            idx_nxt     = scan_idx;
            onehot_nxt  = beat_onehot;
            zero_nxt    = 1'b0;
            last_nxt    = beat_last;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pending  <= '0;
      ptr      <= '0;
      mode_q   <= MODE_FIXED;
      idx_o    <= '0;
      onehot_o <= '0;
      zero_o   <= 1'b0;
      last_o   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      ptr      <= ptr_nxt;
      mode_q   <= mode_nxt;
      idx_o    <= idx_nxt;
      onehot_o <= onehot_nxt;
      zero_o   <= zero_nxt;
      last_o   <= last_nxt;
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: an N=8 LSB-first instance and an N=5 MSB-first
// instance, with expected beats queued by the stimulus and retired by a monitor.
module tb_prio_encoder_rr;

  typedef struct {
    int idx;
    bit zero;
    bit last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  beat_t qa[$];
  beat_t qb[$];

  // Instance A: N=8, lowest set bit first
  logic       a_rst, a_mode, a_req_valid, a_req_ready, a_zero, a_last, a_out_valid, a_out_ready;
  logic [7:0] a_req, a_onehot;
  logic [2:0] a_idx;

  prio_encoder_rr #(.N(8), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(a_rst), .mode(a_mode), .req_i(a_req), .req_valid(a_req_valid),
    .req_ready(a_req_ready), .idx_o(a_idx), .onehot_o(a_onehot), .zero_o(a_zero),
    .last_o(a_last), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  // Instance B: N=5, highest set bit first
  logic       b_rst, b_mode, b_req_valid, b_req_ready, b_zero, b_last, b_out_valid, b_out_ready;
  logic [4:0] b_req, b_onehot;
  logic [2:0] b_idx;

  prio_encoder_rr #(.N(5), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(b_rst), .mode(b_mode), .req_i(b_req), .req_valid(b_req_valid),
    .req_ready(b_req_ready), .idx_o(b_idx), .onehot_o(b_onehot), .zero_o(b_zero),
    .last_o(b_last), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  // Monitor: retires one expected beat per observed handshake
  always @(negedge clk) begin
    beat_t e;
    logic [7:0] oh_a;
    logic [4:0] oh_b;
    if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_beat actual idx=%0d zero=%0b last=%0b required=no beat",
                 a_idx, a_zero, a_last);
      end else begin
        e = qa.pop_front();
        oh_a = '0;
        if (!e.zero) oh_a[e.idx] = 1'b1;
        if (a_idx !== 3'(e.idx) || a_onehot !== oh_a || a_zero !== e.zero || a_last !== e.last) begin
          errors++;
          $display("FAIL a_beat actual idx=%0d oh=%b zero=%0b last=%0b required idx=%0d oh=%b zero=%0b last=%0b",
                   a_idx, a_onehot, a_zero, a_last, e.idx, oh_a, e.zero, e.last);
        end
      end
    end
    if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_beat actual idx=%0d zero=%0b last=%0b required=no beat",
                 b_idx, b_zero, b_last);
      end else begin
        e = qb.pop_front();
        oh_b = '0;
        if (!e.zero) oh_b[e.idx] = 1'b1;
        if (b_idx !== 3'(e.idx) || b_onehot !== oh_b || b_zero !== e.zero || b_last !== e.last) begin
          errors++;
          $display("FAIL b_beat actual idx=%0d oh=%b zero=%0b last=%0b required idx=%0d oh=%b zero=%0b last=%0b",
                   b_idx, b_onehot, b_zero, b_last, e.idx, oh_b, e.zero, e.last);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic exp_a(input int idx, input bit zero, input bit last);
    beat_t e;
    e.idx = idx; e.zero = zero; e.last = last;
    qa.push_back(e);
  endtask

  task automatic exp_b(input int idx, input bit zero, input bit last);
    beat_t e;
    e.idx = idx; e.zero = zero; e.last = last;
    qb.push_back(e);
  endtask

  task automatic send_a(input logic m, input logic [7:0] v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_req_ready !== 1'b1 && n < 100);
    chk("a_accept_wait", int'(a_req_ready === 1'b1), 1);
    a_mode = m; a_req = v; a_req_valid = 1'b1;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
  endtask

  task automatic send_b(input logic m, input logic [4:0] v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b_req_ready !== 1'b1 && n < 100);
    chk("b_accept_wait", int'(b_req_ready === 1'b1), 1);
    b_mode = m; b_req = v; b_req_valid = 1'b1;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int n;
    n = 0;
    while ((sel ? qb.size() : qa.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(sel ? "b_drain_left" : "a_drain_left", sel ? qb.size() : qa.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    a_rst = 1'b1; a_mode = 1'b0; a_req = '0; a_req_valid = 1'b0; a_out_ready = 1'b1;
    b_rst = 1'b1; b_mode = 1'b0; b_req = '0; b_req_valid = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_req_ready", int'(a_req_ready), 1);
    chk("a_rst_out_valid", int'(a_out_valid), 0);
    chk("a_rst_outputs", int'({a_idx, a_onehot, a_zero, a_last}), 0);
    chk("b_rst_req_ready", int'(b_req_ready), 1);
    chk("b_rst_out_valid", int'(b_out_valid), 0);
    a_rst = 1'b0; b_rst = 1'b0;

    // Fixed priority, lowest first
    exp_a(1, 0, 0); exp_a(2, 0, 0); exp_a(5, 0, 0); exp_a(7, 0, 1);
    send_a(1'b0, 8'b1010_0110);
    drain(0);
    chk("a_ready_after_vec", int'(a_req_ready), 1);
    chk("a_idle_out_valid", int'(a_out_valid), 0);

    // Round robin with ptr wrap and persistence across vectors
    exp_a(0, 0, 0); exp_a(7, 0, 1);
    send_a(1'b1, 8'b1000_0001);
    exp_a(0, 0, 0); exp_a(7, 0, 1);
    send_a(1'b1, 8'b1000_0001);
    exp_a(2, 0, 1);
    send_a(1'b1, 8'b0000_0100);
    exp_a(4, 0, 0); exp_a(0, 0, 1);
    send_a(1'b1, 8'b0001_0001);
    // Zero vector: single beat, pointer left at 1
    exp_a(0, 1, 1);
    send_a(1'b1, 8'h00);
    exp_a(1, 0, 0); exp_a(0, 0, 1);
    send_a(1'b1, 8'b0000_0011);
    drain(0);

    // Stall: outputs hold while out_ready is low
    a_out_ready = 1'b0;
    exp_a(2, 0, 0); exp_a(3, 0, 1);
    send_a(1'b0, 8'b0000_1100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("a_stall_hold", int'({a_out_valid, a_idx, a_onehot, a_last, a_zero}),
          int'({1'b1, 3'd2, 8'b0000_0100, 1'b0, 1'b0}));
    end
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    drain(0);

    // Reset mid-scan after two beats
    exp_a(0, 0, 0); exp_a(1, 0, 0);
    send_a(1'b0, 8'hFF);
    @(posedge clk);
    @(posedge clk);
    #1 a_rst = 1'b1; a_out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("a_midrst_out_valid", int'(a_out_valid), 0);
    chk("a_midrst_req_ready", int'(a_req_ready), 1);
    chk("a_midrst_outputs", int'({a_idx, a_onehot, a_zero, a_last}), 0);
    a_rst = 1'b0; a_out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("a_midrst_queue", qa.size(), 0);
    // Pointer back at 0 after reset: RR visits 0 before 1
    exp_a(0, 0, 0); exp_a(1, 0, 1);
    send_a(1'b1, 8'b0000_0011);
    drain(0);

    // N=5 fixed, highest first; then RR wrap from idx N-1
    exp_b(4, 0, 0); exp_b(1, 0, 0); exp_b(0, 0, 1);
    send_b(1'b0, 5'b10011);
    exp_b(4, 0, 1);
    send_b(1'b1, 5'b10000);
    exp_b(0, 0, 0); exp_b(1, 0, 1);
    send_b(1'b1, 5'b00011);
    drain(1);
    chk("b_ready_after_vec", int'(b_req_ready), 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
